mem_store_unit: RTL and testbench
=================================

// Module: mem_store_unit
// PURPOSE
//  Write-side counterpart of the B operand register in the multicycle datapath: takes the
//  captured store data (B) and the effective address (ALUOut) in the MemWrite step, and
//  drives one aligned, byte-enabled write transaction to data memory over a req/ack handshake.
//  Signals completion or error to the control FSM, which holds MemWrite until done/err.
// PARAMETERS
//  ACK_TIMEOUT  16  cycles mem_req may wait for mem_ack before aborting with err (>=2)
//  BIG_ENDIAN   0   0: byte 0 in wdata[7:0]; 1: byte 0 in wdata[31:24] (lane mirroring)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  start        in   1   1-cycle request from control FSM; sampled only in IDLE
//  size         in   2   00 byte, 01 half, 10 word, 11 reserved
//  addr         in   32  byte address of the store
//  wdata        in   32  store data (right-justified, from B register)
//  busy         out  1   high from cycle after accepted start until done/err cycle inclusive
//  done         out  1   1-cycle pulse: write acknowledged
//  err          out  1   1-cycle pulse: misaligned, reserved size, or ack timeout
//  mem_req      out  1   write request, held until mem_ack or timeout
//  mem_we       out  1   equals mem_req (unit issues writes only)
//  mem_addr     out  32  {addr[31:2],2'b00}, registered at start
//  mem_be       out  4   byte enables, registered at start
//  mem_wdata    out  32  lane-replicated data, registered at start
//  mem_ack      in   1   memory accepted the write; ignored unless mem_req high
// BEHAVIOUR
//  Reset (rst=0, immediate): state IDLE; busy, done, err, mem_req, mem_we = 0;
//   mem_addr, mem_be, mem_wdata = 0; timeout counter = 0.
//  States: IDLE, REQ, DONE, ERR (one-hot or binary; encoding in package).
//  IDLE: start & legal -> REQ, latch mem_addr/mem_be/mem_wdata, clear counter.
//   start & illegal (size=11, half with addr[0]=1, word with addr[1:0]!=0) -> ERR;
//   no memory transaction issued. No start -> stay.
//  REQ: mem_req=mem_we=1, outputs stable. mem_ack=1 -> DONE. Else counter+1;
//   counter==ACK_TIMEOUT-1 without ack -> ERR, mem_req drops that same transition.
//   Ack in the same cycle as the timeout expiry: ack wins -> DONE.
//  DONE: done=1 for one cycle -> IDLE. ERR: err=1 for one cycle -> IDLE.
//  Latency: start at edge N -> mem_req high after edge N; ack sampled at edge N+k ->
//   done high for cycle after N+k. Minimum start-to-done: 2 cycles (ack in first REQ cycle).
//  start while not IDLE (REQ/DONE/ERR) is ignored, not queued; controller must wait for done/err.
//  mem_ack outside REQ is ignored. done and err never both high.
//  Lane rules (little-endian, k=addr[1:0]):
//   byte: be=4'b0001<<k, wdata_out={4{wdata[7:0]}}
//   half: be=addr[1]?4'b1100:4'b0011, wdata_out={2{wdata[15:0]}}
//   word: be=4'b1111, wdata_out=wdata
//   BIG_ENDIAN=1: be bit-reversed; data lanes byte-swapped accordingly.
//  Reset asserted mid-REQ aborts: mem_req drops asynchronously, no done/err pulse.
// STRUCTURE
//  Shared package: size codes (SZ_BYTE/SZ_HALF/SZ_WORD), state encoding, ACK_TIMEOUT default.
//  One sub-module: store_lane_align (combinational: size, addr[1:0], wdata -> be, lane data,
//   illegal flag); top holds FSM, timeout counter, output registers.
// TESTING
//  word sw: addr=0x100, wdata=0xDEADBEEF, ack after 1 cycle -> mem_addr=0x100, be=1111,
//   mem_wdata=0xDEADBEEF, done pulse 2 cycles after start, busy 2 cycles.
//  sb: addr=0x103, wdata=0x000000A5 -> mem_addr=0x100, be=1000, mem_wdata=0xA5A5A5A5.
//  sh: addr=0x102, wdata=0x1234 -> be=1100, mem_wdata=0x12341234; addr=0x101 -> err pulse,
//   mem_req never asserted.
//  timeout: ACK_TIMEOUT=16, mem_ack held 0 -> mem_req high exactly 16 cycles, then err pulse;
//   ack on 16th cycle instead -> done, no err.
//  start pulses during REQ and stray mem_ack in IDLE -> ignored, exactly one transaction.
//  rst low during REQ -> mem_req/busy 0 same cycle, no done; next start works normally.

Source files
------------

// File: rtl/mem_store_unit_pkg.sv
// Shared definitions for the store unit: access-size codes, FSM state encoding,
// the default ack timeout and the lane-mirroring helpers used for big-endian buses.
package mem_store_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } state_e;

  localparam int ACK_TIMEOUT_DEFAULT = 16;

  function automatic logic [3:0] reverse_be(input logic [3:0] be);
    return {be[0], be[1], be[2], be[3]};
  endfunction

  function automatic logic [31:0] swap_bytes(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/mem_store_unit_if.sv
// Write-only data-memory bus between the store unit (master) and memory (slave).
interface mem_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack
  );
endinterface

// File: rtl/mem_store_unit_store_lane_align.sv
// Combinational lane steering: turns size, low address bits and right-justified store
// data into byte enables, replicated lane data and an alignment-error flag.
module store_lane_align
  import mem_store_unit_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_data,
  output logic        illegal
);

  logic [3:0]  le_be;
  logic [31:0] le_data;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    le_be   = 4'b0000;
    le_data = 32'h0;
    illegal = 1'b0;
    case (size)
      SZ_BYTE: begin
        le_be   = 4'b0001 << addr_lo;
        le_data = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        illegal = addr_lo[0];
        le_be   = addr_lo[1] ? 4'b1100 : 4'b0011;
        le_data = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        illegal = (addr_lo != 2'b00);
        le_be   = 4'b1111;
        le_data = wdata;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Big-endian buses put byte 0 in the top lane, so enables and data are mirrored.
  assign be        = BIG_ENDIAN ? reverse_be(le_be)   : le_be;
  assign lane_data = BIG_ENDIAN ? swap_bytes(le_data) : le_data;

endmodule

// File: rtl/mem_store_unit.sv
// Store unit for the multicycle datapath: latches an aligned, byte-enabled write at start,
// holds mem_req until ack or timeout, and reports a one-cycle done or err to control.
module mem_store_unit
  import mem_store_unit_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT,
  parameter bit BIG_ENDIAN  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         size,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  mem_store_unit_if.master   mem
);

  localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        addr_q, wdata_q;
  logic [3:0]         be_q;
  logic [3:0]         be_c;
  logic [31:0]        data_c;
  logic               illegal;
  logic               accept;
  logic               timeout_hit;
  logic               req;

  store_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .size      (size_e'(size)),
    .addr_lo   (addr[1:0]),
    .wdata     (wdata),
    .be        (be_c),
    .lane_data (data_c),
    .illegal   (illegal)
  );

  assign accept      = (state == ST_IDLE) && start && !illegal;
  assign timeout_hit = (cnt == CNT_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = illegal ? ST_ERR : ST_REQ;
      // An ack arriving on the expiry cycle still completes the write.
      ST_REQ: begin
        if (mem.mem_ack)      state_nxt = ST_DONE;
        else if (timeout_hit) state_nxt = ST_ERR;
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the bus registers are reset as well, so memory never sees X address/data after reset.
    if (!rst) begin
      addr_q  <= 32'h0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      cnt     <= '0;
    end else if (accept) begin
      addr_q  <= {addr[31:2], 2'b00};
      be_q    <= be_c;
      wdata_q <= data_c;
      cnt     <= '0;
    end else if (state == ST_REQ) begin
      cnt <= cnt + 1'b1;
    end
  end

  // All handshake outputs decode the state register, so reset clears them immediately.
  assign req           = (state == ST_REQ);
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);
  assign err           = (state == ST_ERR);
  assign mem.mem_req   = req;
  assign mem.mem_we    = req;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_store_unit.sv
// Self-checking bench for mem_store_unit: directed vector table, multi-cycle corner
// sequences and random stores compared against a lane-level reference model.
module tb_mem_store_unit;
  import mem_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        busy, done, err;
  logic        busy_b, done_b, err_b;

  int total = 0;
  int bad   = 0;

  mem_store_unit_if bus_le();
  mem_store_unit_if bus_be();
  assign bus_le.mem_ack = ack;
  assign bus_be.mem_ack = ack;

  mem_store_unit #(.ACK_TIMEOUT(16), .BIG_ENDIAN(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .size(size), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .mem(bus_le)
  );

  mem_store_unit #(.ACK_TIMEOUT(16), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst), .start(start), .size(size), .addr(addr), .wdata(wdata),
    .busy(busy_b), .done(done_b), .err(err_b), .mem(bus_be)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          legal;
    logic [3:0]  be;
    logic [31:0] data;
  } lane_t;

  typedef struct {
    bit          done_seen, err_seen, timed_out;
    bit          we_ok, stable_ok, excl_ok, idle_ok, sync_ok;
    int          end_cyc, req_cyc, busy_cyc, req_edges;
    logic [31:0] addr, data, data_b;
    logic [3:0]  be, be_b;
  } res_t;

  typedef struct {
    logic [1:0]  sz;
    logic [31:0] addr, wdata;
    int          ack_at;
    bit          exp_done;
    int          exp_end, exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_data;
  } vec_t;

  // Lane i of the bus covers byte address {addr[31:2], i}; it is written when that byte
  // falls inside the access, and carries store byte (i mod access size).
  function automatic lane_t model(input logic [1:0] sz, input logic [31:0] a,
                                  input logic [31:0] d, input bit big);
    lane_t r;
    int n, off, j;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off = int'(a[1:0]);
    r.legal = (sz != 2'b11) && (off % n == 0);
    r.be    = '0;
    r.data  = '0;
    for (int i = 0; i < 4; i++) begin
      j = big ? 3 - i : i;
      r.be[j] = (i >= off) && (i < off + n);
      r.data[8*j +: 8] = d[8*(i % n) +: 8];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // One store: start pulse, ack driven during REQ cycle ack_at (0 = never), then one idle cycle.
  task automatic run_txn(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                         input int ack_at, input bit spam, output res_t r);
    bit prev_req;
    r = '{default: 0};
    r.we_ok = 1; r.stable_ok = 1; r.excl_ok = 1; r.sync_ok = 1;
    prev_req = 1'b0;
    @(negedge clk);
    size = sz; addr = a; wdata = d; start = 1'b1; ack = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus_le.mem_req) begin
        if (r.req_cyc == 0) begin
          r.addr = bus_le.mem_addr; r.be = bus_le.mem_be; r.data = bus_le.mem_wdata;
          r.be_b = bus_be.mem_be;   r.data_b = bus_be.mem_wdata;
        end else if (bus_le.mem_addr !== r.addr || bus_le.mem_be !== r.be ||
                     bus_le.mem_wdata !== r.data) begin
          r.stable_ok = 0;
        end
        r.req_cyc++;
      end
      if (bus_le.mem_req && !prev_req) r.req_edges++;
      prev_req = bus_le.mem_req;
      if (bus_le.mem_we !== bus_le.mem_req) r.we_ok = 0;
      if (done && err) r.excl_ok = 0;
      if (done_b !== done || err_b !== err || busy_b !== busy) r.sync_ok = 0;
      if (busy) r.busy_cyc++;
      if (done || err) begin
        r.done_seen = done; r.err_seen = err; r.end_cyc = c;
        ack = 1'b0;
        break;
      end
      ack = (c == ack_at);
      if (spam) begin
        start = 1'b1; size = SZ_WORD; addr = 32'h0000_0300; wdata = $urandom;
      end
    end
    start = 1'b0;
    ack   = 1'b0;
    if (!r.done_seen && !r.err_seen) r.timed_out = 1;
    @(negedge clk);
    r.idle_ok = !busy && !done && !err && !bus_le.mem_req;
  endtask

  task automatic check_result(input string tag, input res_t r, input bit exp_done,
                              input int exp_end, input int exp_req, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_data,
                              input lane_t mb);
    check({tag, ".done"}, 32'(r.done_seen), 32'(exp_done));
    check({tag, ".err"},  32'(r.err_seen),  32'(!exp_done));
    check({tag, ".end_cycle"},  r.end_cyc,  exp_end);
    check({tag, ".req_cycles"}, r.req_cyc,  exp_req);
    check({tag, ".busy_cycles"}, r.busy_cyc, exp_end);
    check({tag, ".flags"}, 32'({r.we_ok, r.stable_ok, r.excl_ok, r.idle_ok, r.sync_ok,
                                !r.timed_out}), 32'h3F);
    if (exp_req > 0) begin
      check({tag, ".mem_addr"},  r.addr, exp_addr);
      check({tag, ".mem_be"},    32'(r.be), 32'(exp_be));
      check({tag, ".mem_wdata"}, r.data, exp_data);
      check({tag, ".be_mem_be"},    32'(r.be_b), 32'(mb.be));
      check({tag, ".be_mem_wdata"}, r.data_b, mb.data);
    end
  endtask

  initial begin
    vec_t  vecs [11];
    res_t  r;
    lane_t m, mb;
    bit    ok;
    logic [1:0]  rsz;
    logic [31:0] ra, rd;
    int    rack, e_end, e_req;

    rst = 1'b0; start = 1'b0; ack = 1'b0; size = 2'b00; addr = 32'h0; wdata = 32'h0;

    vecs[0]  = '{SZ_WORD, 32'h0000_0100, 32'hDEAD_BEEF, 1,  1'b1, 2,  1,  32'h0000_0100, 4'b1111, 32'hDEAD_BEEF};
    vecs[1]  = '{SZ_BYTE, 32'h0000_0103, 32'h0000_00A5, 3,  1'b1, 4,  3,  32'h0000_0100, 4'b1000, 32'hA5A5_A5A5};
    vecs[2]  = '{SZ_HALF, 32'h0000_0102, 32'h0000_1234, 2,  1'b1, 3,  2,  32'h0000_0100, 4'b1100, 32'h1234_1234};
    vecs[3]  = '{SZ_HALF, 32'h0000_0101, 32'h0000_1234, 1,  1'b0, 1,  0,  32'h0, 4'b0000, 32'h0};
    vecs[4]  = '{SZ_WORD, 32'h0000_0104, 32'hCAFE_F00D, 0,  1'b0, 17, 16, 32'h0000_0104, 4'b1111, 32'hCAFE_F00D};
    vecs[5]  = '{SZ_WORD, 32'h0000_0108, 32'h0123_4567, 16, 1'b1, 17, 16, 32'h0000_0108, 4'b1111, 32'h0123_4567};
    vecs[6]  = '{SZ_RSVD, 32'h0000_0200, 32'h1111_2222, 1,  1'b0, 1,  0,  32'h0, 4'b0000, 32'h0};
    vecs[7]  = '{SZ_WORD, 32'h0000_0202, 32'h3333_4444, 1,  1'b0, 1,  0,  32'h0, 4'b0000, 32'h0};
    vecs[8]  = '{SZ_BYTE, 32'h0000_0101, 32'h0000_0077, 1,  1'b1, 2,  1,  32'h0000_0100, 4'b0010, 32'h7777_7777};
    vecs[9]  = '{SZ_HALF, 32'h0000_0200, 32'h0000_ABCD, 5,  1'b1, 6,  5,  32'h0000_0200, 4'b0011, 32'hABCD_ABCD};
    vecs[10] = '{SZ_BYTE, 32'h1000_0000, 32'hFFFF_FF5A, 17, 1'b0, 17, 16, 32'h1000_0000, 4'b0001, 32'h5A5A_5A5A};

    // Reset state
    #12;
    check("reset.ctrl", 32'({busy, done, err, bus_le.mem_req, bus_le.mem_we}), 32'h0);
    check("reset.mem_addr",  bus_le.mem_addr, 32'h0);
    check("reset.mem_be",    32'(bus_le.mem_be), 32'h0);
    check("reset.mem_wdata", bus_le.mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      mb = model(vecs[i].sz, vecs[i].addr, vecs[i].wdata, 1'b1);
      run_txn(vecs[i].sz, vecs[i].addr, vecs[i].wdata, vecs[i].ack_at, 1'b0, r);
      check_result($sformatf("vec%0d", i), r, vecs[i].exp_done, vecs[i].exp_end,
                   vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_be, vecs[i].exp_data, mb);
    end

    // Stray ack while idle, then start pulses repeated throughout REQ
    ok = 1'b1;
    ack = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (busy || done || err || bus_le.mem_req) ok = 1'b0;
    end
    ack = 1'b0;
    check("stray_ack.idle", 32'(ok), 32'h1);
    mb = model(SZ_HALF, 32'h0000_0506, 32'h0000_BEEF, 1'b1);
    run_txn(SZ_HALF, 32'h0000_0506, 32'h0000_BEEF, 4, 1'b1, r);
    check_result("spam", r, 1'b1, 5, 4, 32'h0000_0504, 4'b1100, 32'hBEEF_BEEF, mb);
    check("spam.req_edges", r.req_edges, 1);
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus_le.mem_req || busy) ok = 1'b0;
    end
    check("spam.no_second_txn", 32'(ok), 32'h1);

    // Reset in the middle of REQ
    @(negedge clk);
    size = SZ_WORD; addr = 32'h0000_0400; wdata = 32'h5555_AAAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid.req_before", 32'(bus_le.mem_req), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid.req_busy", 32'({bus_le.mem_req, busy, done, err}), 32'h0);
    check("rst_mid.mem_addr", bus_le.mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || err || busy || bus_le.mem_req) ok = 1'b0;
    end
    check("rst_mid.quiet_after", 32'(ok), 32'h1);
    mb = model(SZ_BYTE, 32'h0000_0602, 32'h0000_003C, 1'b1);
    run_txn(SZ_BYTE, 32'h0000_0602, 32'h0000_003C, 2, 1'b0, r);
    check_result("rst_mid.next", r, 1'b1, 3, 2, 32'h0000_0600, 4'b0100, 32'h3C3C_3C3C, mb);

    // Random stores against the lane model
    for (int i = 0; i < 40; i++) begin
      rsz  = 2'($urandom_range(0, 3));
      ra   = $urandom;
      rd   = $urandom;
      rack = int'($urandom_range(1, 18));
      m  = model(rsz, ra, rd, 1'b0);
      mb = model(rsz, ra, rd, 1'b1);
      if (!m.legal)     begin e_end = 1;        e_req = 0;    end
      else if (rack <= 16) begin e_end = rack + 1; e_req = rack; end
      else              begin e_end = 17;       e_req = 16;   end
      run_txn(rsz, ra, rd, rack, 1'b0, r);
      check_result($sformatf("rand%0d", i), r, m.legal && (rack <= 16), e_end, e_req,
                   {ra[31:2], 2'b00}, m.be, m.data, mb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
